laa_cmd_scheduler: RTL and testbench
====================================

// Module: laa_cmd_scheduler
// PURPOSE
//  Sequences custom LAA instructions (opcode 7'b0001011) from the core into the LAA register/multiply unit.
//  Queues instructions with their rs1 operand, issues one LAA bus operation at a time and returns READ data
//  to core writeback. After MULTIPLY it polls the done register until non-zero or timeout.
//  Sits between the core's decode stage and the LAA instance; its busy output stalls the core.
// PARAMETERS
//  DEPTH        4     command FIFO entries (power of 2, >=2)
//  MUL_TIMEOUT  256   max poll cycles after MULTIPLY before timeout error (>=2)
//  DONE_REG     31    LAA register polled for multiply completion
// PORTS
//  clk           in   1   clock, rising edge
//  Rst           in   1   asynchronous, active-low reset
//  cmd_valid     in   1   core offers instruction
//  cmd_ready     out  1   FIFO can accept (= !full)
//  cmd_ins       in   32  raw instruction
//  cmd_rs1_data  in   32  core rs1 value for WRITE
//  laa_opcode    out  2   NONE=0 READ=1 WRITE=2 MULTIPLY=3
//  laa_addr      out  5   LAA register address
//  laa_data_in   out  32  write data to LAA
//  laa_data_out  in   32  LAA read data, valid 1 cycle after READ issued
//  wb_valid      out  1   one-cycle writeback strobe (regwrite)
//  wb_rd         out  5   core destination register
//  wb_data       out  32  writeback value
//  laa_busy      out  1   FIFO non-empty or FSM not IDLE
//  illegal_ins   out  1   one-cycle pulse: popped entry discarded
//  timeout_err   out  1   sticky, multiply poll timed out
//  err_clr       in   1   clears timeout_err (set wins if same cycle)
// BEHAVIOUR
//  Reset (Rst=0, async): FIFO empty, FSM IDLE, all outputs 0 except cmd_ready=1; mid-operation reset aborts
//   the operation with no writeback.
//  Push on cmd_valid&&cmd_ready at edge; full => cmd_ready=0, no push. Pointers wrap mod DEPTH.
//   Push+pop same edge allowed when not full; no bypass (empty->push, earliest pop next edge).
//  Decode of popped entry: legal iff ins[6:0]==7'b0001011 and ins[11:7] in {00010 WRITE, 00001 READ,
//   00011 MULTIPLY}; otherwise illegal_ins pulses, entry dropped, FSM stays IDLE.
//  FSM (registered state; LAA outputs are decoded from state + current-entry register):
//   IDLE: laa_opcode=NONE. FIFO non-empty => pop into current-entry reg -> DISPATCH.
//   DISPATCH (1 cycle):
//    WRITE: opcode=WRITE, addr=ins[26:22], data_in=rs1_data -> IDLE.
//    READ: opcode=READ, addr=ins[31:27] -> RD_WAIT.
//    MULTIPLY: opcode=MULTIPLY -> MUL_POLL, poll counter=0.
//   RD_WAIT (1 cycle): opcode=NONE. Capture laa_data_out into wb_data, wb_rd=ins[26:22].
//    wb_valid=1 next cycle, unless rd==0. -> IDLE.
//   MUL_POLL: opcode=READ, addr=DONE_REG each cycle; counter++.
//    From the 2nd poll cycle, laa_data_out!=0 => IDLE.
//    Counter reaching MUL_TIMEOUT => timeout_err=1 -> IDLE. Done wins over timeout on the same cycle.
//  laa_data_in=0 and laa_addr=0 whenever the opcode does not use them. wb_valid is never held >1 cycle.
//  Latency from accept edge E (FIFO previously empty, FSM IDLE):
//   pop at E+1; op on LAA bus in cycle E+1..E+2; READ wb_valid high in cycle E+3..E+4.
//  Throughput: one WRITE per 2 cycles (DISPATCH+IDLE).
//  laa_busy is combinational from FIFO count and state.
// TESTING
//  1 Reset: hold Rst=0 with cmd_valid=1 -> cmd_ready=1, laa_opcode=0, wb_valid=0, laa_busy=0, no push.
//  2 WRITE ins[31:27]=5, ins[26:22]=7, func 00010, rs1=0xDEADBEEF -> one cycle opcode=2, addr=7,
//    data_in=0xDEADBEEF.
//  3 READ LAA reg 7 -> core rd 9, LAA returns 0x1234 -> exactly one wb_valid, wb_rd=9, wb_data=0x1234;
//    rd=0 gives no wb_valid.
//  4 MULTIPLY, done reg reads 0 for 5 cycles then 1 -> opcode=3 once, READ addr 31 polls, IDLE,
//    timeout_err=0; never-done -> timeout_err=1 after 256 polls.
//  5 Push DEPTH+1 legal WRITEs back-to-back -> cmd_ready low when full, all issued in order, wraps cleanly.
//  6 ins[6:0]=0x33, then func 00111 with LAA opcode -> two illegal_ins pulses, no LAA op; next command issues.
//    Rst=0 in MUL_POLL aborts to IDLE.

Source files
------------

// File: rtl/laa_cmd_scheduler.sv
// LAA command scheduler: queues custom LAA instructions from decode, issues
// one LAA bus operation at a time, returns READ data to writeback and polls
// the done register after MULTIPLY.
module laa_cmd_scheduler #(
    parameter int DEPTH       = 4,
    parameter int MUL_TIMEOUT = 256,
    parameter int DONE_REG    = 31
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_ins,
    input  logic [31:0] cmd_rs1_data,
    output logic [1:0]  laa_opcode,
    output logic [4:0]  laa_addr,
    output logic [31:0] laa_data_in,
    input  logic [31:0] laa_data_out,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        laa_busy,
    output logic        illegal_ins,
    output logic        timeout_err,
    input  logic        err_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = AW + 1;
    localparam int CW = $clog2(MUL_TIMEOUT + 1);

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_MUL   = 2'd3;

    localparam logic [6:0] LAA_OPC   = 7'b0001011;
    localparam logic [4:0] F_READ    = 5'b00001;
    localparam logic [4:0] F_WRITE   = 5'b00010;
    localparam logic [4:0] F_MUL     = 5'b00011;

    // Only the fields the scheduler needs are queued; legality is decided at push.
    typedef struct packed {
        logic        legal;
        logic [4:0]  func;
        logic [4:0]  hi;    // ins[31:27]: READ source register
        logic [4:0]  lo;    // ins[26:22]: WRITE target / READ destination rd
        logic [31:0] rs1;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_RD_WAIT, S_MUL_POLL} state_t;

    state_t          state, state_nxt;
    entry_t          fifo_mem [0:DEPTH-1];
    entry_t          cur, push_ent, head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [NW-1:0]   count;
    logic [CW-1:0]   poll_cnt;
    logic            full, empty, push, pop;
    logic            poll_done, poll_tmo;
    logic            unused_ins_bits;

    assign unused_ins_bits = ^cmd_ins[21:12];

    assign full      = (count == NW'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_IDLE) && !empty;
    assign head      = fifo_mem[rd_ptr];
    assign laa_busy  = !empty || (state != S_IDLE);

    // Decode incoming instruction into a queue entry.
    always_comb begin
        push_ent       = '0;
        push_ent.legal = (cmd_ins[6:0] == LAA_OPC) &&
                         (cmd_ins[11:7] == F_READ || cmd_ins[11:7] == F_WRITE ||
                          cmd_ins[11:7] == F_MUL);
        push_ent.func  = cmd_ins[11:7];
        push_ent.hi    = cmd_ins[31:27];
        push_ent.lo    = cmd_ins[26:22];
        push_ent.rs1   = cmd_rs1_data;
    end

    // Queue storage; contents are only meaningful between pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_ent;
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + NW'(push) - NW'(pop);
        end
    end

    // Done is only trusted from the 2nd poll cycle since READ data lags by one cycle.
    assign poll_done = (state == S_MUL_POLL) && (poll_cnt != '0) && (laa_data_out != '0);
    assign poll_tmo  = (state == S_MUL_POLL) && !poll_done &&
                       (poll_cnt == CW'(MUL_TIMEOUT - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (pop && head.legal) state_nxt = S_DISPATCH;
            S_DISPATCH: begin
                case (cur.func)
                    F_READ:  state_nxt = S_RD_WAIT;
                    F_MUL:   state_nxt = S_MUL_POLL;
                    default: state_nxt = S_IDLE;
                endcase
            end
            S_RD_WAIT:  state_nxt = S_IDLE;
            S_MUL_POLL: if (poll_done || poll_tmo) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: LAA bus decoded from state and the current entry.
    always_comb begin
        laa_opcode  = OP_NONE;
        laa_addr    = '0;
        laa_data_in = '0;
        case (state)
            S_DISPATCH: begin
                case (cur.func)
                    F_WRITE: begin
                        laa_opcode  = OP_WRITE;
                        laa_addr    = cur.lo;
                        laa_data_in = cur.rs1;
                    end
                    F_READ: begin
                        laa_opcode = OP_READ;
                        laa_addr   = cur.hi;
                    end
                    F_MUL:   laa_opcode = OP_MUL;
                    default: laa_opcode = OP_NONE;
                endcase
            end
            S_MUL_POLL: begin
                laa_opcode = OP_READ;
                laa_addr   = 5'(DONE_REG);
            end
            default: laa_opcode = OP_NONE;
        endcase
    end

    // Current entry, poll counter, writeback and error reporting.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            cur         <= '0;
            poll_cnt    <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            illegal_ins <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (pop) cur <= head;
            illegal_ins <= pop && !head.legal;

            if (state == S_DISPATCH)      poll_cnt <= '0;
            else if (state == S_MUL_POLL) poll_cnt <= poll_cnt + 1'b1;

            wb_valid <= 1'b0;
            if (state == S_RD_WAIT) begin
                wb_data  <= laa_data_out;
                wb_rd    <= cur.lo;
                wb_valid <= (cur.lo != '0);
            end

            if (poll_tmo)     timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_laa_cmd_scheduler.sv
// Directed bench for laa_cmd_scheduler with a small LAA register-file model.
module tb_laa_cmd_scheduler;

    logic        clk = 1'b0;
    logic        Rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_ins;
    logic [31:0] cmd_rs1_data;
    logic [1:0]  laa_opcode;
    logic [4:0]  laa_addr;
    logic [31:0] laa_data_in;
    logic [31:0] laa_data_out;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        laa_busy;
    logic        illegal_ins;
    logic        timeout_err;
    logic        err_clr;

    int errors = 0;
    int checks = 0;

    laa_cmd_scheduler #(.DEPTH(4), .MUL_TIMEOUT(256), .DONE_REG(31)) dut (
        .clk(clk), .Rst(Rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ins(cmd_ins), .cmd_rs1_data(cmd_rs1_data),
        .laa_opcode(laa_opcode), .laa_addr(laa_addr),
        .laa_data_in(laa_data_in), .laa_data_out(laa_data_out),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .laa_busy(laa_busy), .illegal_ins(illegal_ins),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // LAA model: register file, READ data one cycle later, done register
    // returns 0 for the first done_after polls after a MULTIPLY, then 1.
    logic [31:0] regs [0:31];
    int          done_after = 1000000;
    int          poll_reads = 0;
    always @(posedge clk) begin
        if (laa_opcode == 2'd3) begin
            poll_reads   <= 0;
            laa_data_out <= 32'd0;
        end else if (laa_opcode == 2'd1 && laa_addr == 5'd31) begin
            poll_reads   <= poll_reads + 1;
            laa_data_out <= (poll_reads >= done_after) ? 32'd1 : 32'd0;
        end else if (laa_opcode == 2'd1) begin
            laa_data_out <= regs[laa_addr];
        end else begin
            laa_data_out <= 32'd0;
        end
        if (laa_opcode == 2'd2) regs[laa_addr] <= laa_data_in;
    end

    // Bus monitor: per-cycle event counts and write log.
    int          n_wr = 0, n_rd = 0, n_mul = 0, n_poll = 0, n_wb = 0, n_ill = 0, viol = 0;
    logic        prev_wb = 1'b0;
    logic [4:0]  wr_a [$];
    logic [31:0] wr_d [$];
    always @(negedge clk) begin
        case (laa_opcode)
            2'd0: if (laa_addr != 0 || laa_data_in != 0) viol <= viol + 1;
            2'd1: begin
                if (laa_data_in != 0) viol <= viol + 1;
                if (laa_addr == 5'd31) n_poll <= n_poll + 1;
                else n_rd <= n_rd + 1;
            end
            2'd2: begin
                n_wr <= n_wr + 1;
                wr_a.push_back(laa_addr);
                wr_d.push_back(laa_data_in);
            end
            default: begin
                n_mul <= n_mul + 1;
                if (laa_addr != 0 || laa_data_in != 0) viol <= viol + 1;
            end
        endcase
        if (wb_valid) n_wb <= n_wb + 1;
        if (wb_valid && prev_wb) viol <= viol + 1;
        prev_wb <= wb_valid;
        if (illegal_ins) n_ill <= n_ill + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] f, input logic [4:0] a, input logic [4:0] b);
        return {a, b, 10'd0, f, 7'b0001011};
    endfunction

    // Offer one instruction; returns 1 ns after the accepting edge.
    task automatic push(input logic [31:0] ins, input logic [31:0] rs1);
        int k = 0;
        cmd_valid    = 1'b1;
        cmd_ins      = ins;
        cmd_rs1_data = rs1;
        while (!cmd_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!cmd_ready) chk("push_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while (laa_busy && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("wait_idle", 32'(laa_busy), 32'd0);
    endtask

    int b_wr, b_rd, b_mul, b_poll, b_wb, b_ill;

    task automatic snap();
        b_wr = n_wr; b_rd = n_rd; b_mul = n_mul; b_poll = n_poll; b_wb = n_wb; b_ill = n_ill;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        laa_data_out = 32'd0;
        Rst = 1'b0; err_clr = 1'b0;
        cmd_valid = 1'b1; cmd_ins = mk(5'd2, 5'd5, 5'd7); cmd_rs1_data = 32'h1111_1111;

        // Reset held with a pending command: nothing may be accepted.
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_opcode", 32'(laa_opcode), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_busy", 32'(laa_busy), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        cmd_valid = 1'b0;
        Rst = 1'b1;
        @(negedge clk);
        chk("rst_no_push", 32'(laa_busy), 32'd0);

        // WRITE with cycle-exact bus timing.
        snap();
        push(mk(5'd2, 5'd5, 5'd7), 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_c0_opcode", 32'(laa_opcode), 32'd0);
        chk("wr_c0_busy", 32'(laa_busy), 32'd1);
        @(negedge clk);
        chk("wr_c1_opcode", 32'(laa_opcode), 32'd2);
        chk("wr_c1_addr", 32'(laa_addr), 32'd7);
        chk("wr_c1_data", laa_data_in, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_c2_opcode", 32'(laa_opcode), 32'd0);
        chk("wr_c2_addr", 32'(laa_addr), 32'd0);
        chk("wr_c2_data", laa_data_in, 32'd0);
        chk("wr_c2_busy", 32'(laa_busy), 32'd0);
        chk("wr_count", 32'(n_wr - b_wr), 32'd1);

        // Preload LAA reg 7, then READ it into rd 9.
        push(mk(5'd2, 5'd0, 5'd7), 32'h0000_1234);
        wait_idle(20);
        snap();
        push(mk(5'd1, 5'd7, 5'd9), 32'hFFFF_FFFF);
        @(negedge clk);
        chk("rd_c0_opcode", 32'(laa_opcode), 32'd0);
        @(negedge clk);
        chk("rd_c1_opcode", 32'(laa_opcode), 32'd1);
        chk("rd_c1_addr", 32'(laa_addr), 32'd7);
        chk("rd_c1_data_in", laa_data_in, 32'd0);
        @(negedge clk);
        chk("rd_c2_opcode", 32'(laa_opcode), 32'd0);
        chk("rd_c2_wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        chk("rd_c3_wb_valid", 32'(wb_valid), 32'd1);
        chk("rd_c3_wb_rd", 32'(wb_rd), 32'd9);
        chk("rd_c3_wb_data", wb_data, 32'h0000_1234);
        @(negedge clk);
        chk("rd_c4_wb_valid", 32'(wb_valid), 32'd0);
        chk("rd_wb_count", 32'(n_wb - b_wb), 32'd1);

        // READ to rd 0: bus read happens, no writeback.
        snap();
        push(mk(5'd1, 5'd7, 5'd0), 32'd0);
        repeat (6) @(negedge clk);
        chk("rd0_bus_reads", 32'(n_rd - b_rd), 32'd1);
        chk("rd0_wb_count", 32'(n_wb - b_wb), 32'd0);

        // MULTIPLY: done reads 0 five times, then 1 -> 7 poll cycles.
        done_after = 5;
        snap();
        push(mk(5'd3, 5'd0, 5'd0), 32'd0);
        wait_idle(50);
        chk("mul_ops", 32'(n_mul - b_mul), 32'd1);
        chk("mul_polls", 32'(n_poll - b_poll), 32'd7);
        chk("mul_timeout", 32'(timeout_err), 32'd0);

        // MULTIPLY never done -> timeout after 256 polls, then clear.
        done_after = 1000000;
        snap();
        push(mk(5'd3, 5'd0, 5'd0), 32'd0);
        wait_idle(400);
        chk("tmo_polls", 32'(n_poll - b_poll), 32'd256);
        chk("tmo_flag", 32'(timeout_err), 32'd1);
        @(negedge clk);
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("tmo_cleared", 32'(timeout_err), 32'd0);

        // Fill the FIFO behind a slow MULTIPLY, then one more WRITE.
        done_after = 20;
        snap();
        push(mk(5'd3, 5'd0, 5'd0), 32'd0);
        for (int i = 0; i < 4; i++) push(mk(5'd2, 5'd0, 5'(10 + i)), 32'hA0 + 32'(i));
        chk("full_ready", 32'(cmd_ready), 32'd0);
        push(mk(5'd2, 5'd0, 5'd14), 32'hA4);
        wait_idle(200);
        chk("fill_wr_count", 32'(n_wr - b_wr), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill_addr%0d", i), 32'(wr_a[b_wr + i]), 32'(10 + i));
            chk($sformatf("fill_data%0d", i), wr_d[b_wr + i], 32'hA0 + 32'(i));
        end

        // Illegal instructions are dropped, the next legal one issues.
        snap();
        push(32'h0000_0033, 32'd0);
        push(mk(5'd7, 5'd1, 5'd2), 32'd0);
        repeat (4) @(negedge clk);
        chk("ill_pulses", 32'(n_ill - b_ill), 32'd2);
        chk("ill_no_ops", 32'((n_wr - b_wr) + (n_rd - b_rd) + (n_mul - b_mul) + (n_poll - b_poll)), 32'd0);
        chk("ill_busy", 32'(laa_busy), 32'd0);
        push(mk(5'd2, 5'd0, 5'd3), 32'h55);
        wait_idle(20);
        chk("ill_next_wr", 32'(n_wr - b_wr), 32'd1);
        chk("ill_next_data", wr_d[b_wr], 32'h55);

        // Reset during MUL_POLL aborts the operation.
        done_after = 1000000;
        snap();
        push(mk(5'd3, 5'd0, 5'd0), 32'd0);
        repeat (10) @(negedge clk);
        chk("abort_polling", 32'(laa_opcode), 32'd1);
        Rst = 1'b0;
        #1;
        chk("abort_opcode", 32'(laa_opcode), 32'd0);
        chk("abort_busy", 32'(laa_busy), 32'd0);
        @(negedge clk);
        Rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_idle", 32'(laa_opcode), 32'd0);
        chk("abort_timeout", 32'(timeout_err), 32'd0);
        chk("abort_no_wb", 32'(n_wb - b_wb), 32'd0);

        chk("bus_invariants", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
